// File: rtl/reorder_buffer_if.sv
// ----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every non-clock signal of the reorder buffer.
//   master : issue stage / CDB / register-status side (drives requests,
//            broadcasts and lookup tags; observes accept, commit and lookups)
//   slave  : the reorder buffer itself
// Handshake: an allocation takes place on a rising clock edge where both
// issue_valid and issue_accept are high; issue_accept is combinational and
// issue_valid must not depend on it. cdb_valid and commit_valid are
// single-cycle strobes with no back-pressure.
// dbg_head / dbg_tail / dbg_count expose the pointer state for observation.
// ----------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
);
    logic             issue_valid;
    logic [4:0]       issue_dest;
    logic             issue_reg_write;
    logic             issue_is_branch;
    logic             issue_accept;
    logic [TAG_W-1:0] issue_ROB;
    logic             rob_full;
    logic             rob_empty;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_ROB;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_mispredict;

    logic [TAG_W-1:0] Q_j;
    logic [TAG_W-1:0] Q_k;
    logic             j_ready;
    logic             k_ready;
    logic [XLEN-1:0]  j_value;
    logic [XLEN-1:0]  k_value;

    logic             commit_valid;
    logic [TAG_W-1:0] commit_ROB;
    logic [4:0]       commit_dest;
    logic [XLEN-1:0]  commit_value;
    logic             RegWrite;
    logic             flush;

    logic [TAG_W-1:0] dbg_head;
    logic [TAG_W-1:0] dbg_tail;
    logic [TAG_W:0]   dbg_count;

    modport master (
        output issue_valid, issue_dest, issue_reg_write, issue_is_branch,
        output cdb_valid, cdb_ROB, cdb_value, cdb_mispredict, Q_j, Q_k,
        input  issue_accept, issue_ROB, rob_full, rob_empty,
        input  j_ready, k_ready, j_value, k_value,
        input  commit_valid, commit_ROB, commit_dest, commit_value, RegWrite, flush,
        input  dbg_head, dbg_tail, dbg_count
    );

    modport slave (
        input  issue_valid, issue_dest, issue_reg_write, issue_is_branch,
        input  cdb_valid, cdb_ROB, cdb_value, cdb_mispredict, Q_j, Q_k,
        output issue_accept, issue_ROB, rob_full, rob_empty,
        output j_ready, k_ready, j_value, k_value,
        output commit_valid, commit_ROB, commit_dest, commit_value, RegWrite, flush,
        output dbg_head, dbg_tail, dbg_count
    );
endinterface

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer. Allocates a tag (tail) at issue, captures
// results from the CDB, retires the head entry in program order and drives
// the commit side of the register status table. A committing mispredicted
// branch raises flush, which empties the buffer on the same edge.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   rob   : reorder_buffer_if.slave (issue, CDB, operand lookup, commit,
//           pointer debug outputs)
// Build option:
//   ROB_BYPASS_EN : when defined, operand lookup also forwards a same-cycle
//                   CDB broadcast; otherwise lookups see registered state only.
// ----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input logic              clk,
    input logic              reset,
    reorder_buffer_if.slave  rob
);
    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] reg_write_q, reg_write_d;
    logic [DEPTH-1:0] is_branch_q, is_branch_d;
    logic [DEPTH-1:0] mispredict_q, mispredict_d;
    logic [4:0]       dest_q  [DEPTH];
    logic [4:0]       dest_d  [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [XLEN-1:0]  value_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic full, commit_valid, flush, issue_accept;
    logic j_ready, k_ready;
    logic [XLEN-1:0] j_value, k_value;

    // Status is purely from registered state, so a commit never frees a slot
    // for an issue in the same cycle.
    always_comb begin
        full         = (count_q == FULL_CNT);
        commit_valid = valid_q[head_q] & ready_q[head_q];
        flush        = commit_valid & is_branch_q[head_q] & mispredict_q[head_q];
        issue_accept = rob.issue_valid & ~full & ~flush;
    end

    always_comb begin
        valid_d      = valid_q;
        ready_d      = ready_q;
        reg_write_d  = reg_write_q;
        is_branch_d  = is_branch_q;
        mispredict_d = mispredict_q;
        dest_d       = dest_q;
        value_d      = value_q;
        head_d       = head_q;
        tail_d       = tail_q;

        // Writeback; broadcasts to unallocated tags are dropped.
        if (rob.cdb_valid && valid_q[rob.cdb_ROB]) begin
            ready_d[rob.cdb_ROB] = 1'b1;
            value_d[rob.cdb_ROB] = rob.cdb_value;
            if (is_branch_q[rob.cdb_ROB]) begin
                mispredict_d[rob.cdb_ROB] = rob.cdb_mispredict;
            end
        end

        if (commit_valid) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_ONE;
        end

        // The tail slot is never the valid head when not full, so this
        // cannot collide with the commit above.
        if (issue_accept) begin
            valid_d[tail_q]      = 1'b1;
            ready_d[tail_q]      = 1'b0;
            mispredict_d[tail_q] = 1'b0;
            reg_write_d[tail_q]  = rob.issue_reg_write;
            is_branch_d[tail_q]  = rob.issue_is_branch;
            dest_d[tail_q]       = rob.issue_dest;
            tail_d               = tail_q + TAG_ONE;
        end

        count_d = count_q + {{TAG_W{1'b0}}, issue_accept} - {{TAG_W{1'b0}}, commit_valid};

        // Flush overrides everything above, including the CDB write.
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            ready_q      <= '0;
            reg_write_q  <= '0;
            is_branch_q  <= '0;
            mispredict_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            reg_write_q  <= reg_write_d;
            is_branch_q  <= is_branch_d;
            mispredict_q <= mispredict_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Payload is qualified by valid/ready, so it carries no reset.
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        value_q <= value_d;
    end

    always_comb begin
        j_ready = valid_q[rob.Q_j] & ready_q[rob.Q_j];
        j_value = value_q[rob.Q_j];
        k_ready = valid_q[rob.Q_k] & ready_q[rob.Q_k];
        k_value = value_q[rob.Q_k];
`ifdef ROB_BYPASS_EN
        if (rob.cdb_valid && (rob.cdb_ROB == rob.Q_j) && valid_q[rob.Q_j]) begin
            j_ready = 1'b1;
            j_value = rob.cdb_value;
        end
        if (rob.cdb_valid && (rob.cdb_ROB == rob.Q_k) && valid_q[rob.Q_k]) begin
            k_ready = 1'b1;
            k_value = rob.cdb_value;
        end
`endif
    end

    assign rob.issue_accept = issue_accept;
    assign rob.issue_ROB    = tail_q;
    assign rob.rob_full     = full;
    assign rob.rob_empty    = (count_q == '0);
    assign rob.commit_valid = commit_valid;
    assign rob.commit_ROB   = head_q;
    assign rob.commit_dest  = dest_q[head_q];
    assign rob.commit_value = value_q[head_q];
    assign rob.RegWrite     = commit_valid & reg_write_q[head_q] & (dest_q[head_q] != 5'd0);
    assign rob.flush        = flush;
    assign rob.j_ready      = j_ready;
    assign rob.j_value      = j_value;
    assign rob.k_ready      = k_ready;
    assign rob.k_value      = k_value;
    assign rob.dbg_head     = head_q;
    assign rob.dbg_tail     = tail_q;
    assign rob.dbg_count    = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(4), .XLEN(32)) rif ();
  reorder_buffer #(.TAG_W(4), .DEPTH(16), .XLEN(32)) dut (.clk(clk), .reset(reset), .rob(rif));

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    logic        rw;
    logic        br;
    logic        rdy;
    logic        mp;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_tail;
  int          checks;
  int          errors;

  logic        e_full, e_empty, e_commit, e_flush, e_accept, e_regwrite, e_jr, e_kr;
  logic [31:0] e_jv, e_kv, e_cval;
  logic [4:0]  e_cdest, e_count;
  logic [3:0]  e_head;

  function automatic int find_tag(logic [3:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  task automatic eval_model();
    int jj;
    int kk;
    e_full = (mq.size() == 16);
    e_empty = (mq.size() == 0);
    e_commit = 1'b0; e_flush = 1'b0; e_regwrite = 1'b0;
    e_cdest = 5'd0; e_cval = 32'd0; e_head = m_tail;
    if (mq.size() > 0) begin
      e_head = mq[0].tag;
      e_commit = mq[0].rdy;
      e_flush = mq[0].rdy && mq[0].br && mq[0].mp;
      e_regwrite = mq[0].rdy && mq[0].rw && (mq[0].dest != 5'd0);
      e_cdest = mq[0].dest;
      e_cval = mq[0].val;
    end
    e_accept = rif.issue_valid && !e_full && !e_flush;
    e_count = 5'(mq.size());
    jj = find_tag(rif.Q_j);
    kk = find_tag(rif.Q_k);
    e_jr = 1'b0; e_jv = 32'd0; e_kr = 1'b0; e_kv = 32'd0;
    if (jj >= 0) begin e_jr = mq[jj].rdy; e_jv = mq[jj].val; end
    if (kk >= 0) begin e_kr = mq[kk].rdy; e_kv = mq[kk].val; end
`ifdef ROB_BYPASS_EN
    if (jj >= 0 && rif.cdb_valid && rif.cdb_ROB == rif.Q_j) begin e_jr = 1'b1; e_jv = rif.cdb_value; end
    if (kk >= 0 && rif.cdb_valid && rif.cdb_ROB == rif.Q_k) begin e_kr = 1'b1; e_kv = rif.cdb_value; end
`endif
  endtask

  // One clock: predict, take the edge, update the model, return at negedge.
  task automatic advance();
    ent_t n;
    int c;
    eval_model();
    @(posedge clk);
    if (reset || e_flush) begin
      mq.delete();
      m_tail = 4'd0;
    end else begin
      if (rif.cdb_valid) begin
        c = find_tag(rif.cdb_ROB);
        if (c >= 0) begin
          mq[c].rdy = 1'b1;
          mq[c].val = rif.cdb_value;
          if (mq[c].br) mq[c].mp = rif.cdb_mispredict;
        end
      end
      if (e_commit) void'(mq.pop_front());
      if (e_accept) begin
        n.tag = m_tail; n.dest = rif.issue_dest; n.rw = rif.issue_reg_write;
        n.br = rif.issue_is_branch; n.rdy = 1'b0; n.mp = 1'b0; n.val = 32'd0;
        mq.push_back(n);
        m_tail = m_tail + 4'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    eval_model();
  endtask

  task automatic drive_idle();
    rif.issue_valid = 1'b0; rif.issue_dest = 5'd0; rif.issue_reg_write = 1'b0; rif.issue_is_branch = 1'b0;
    rif.cdb_valid = 1'b0; rif.cdb_ROB = 4'd0; rif.cdb_value = 32'd0; rif.cdb_mispredict = 1'b0;
    rif.Q_j = 4'd0; rif.Q_k = 4'd0;
  endtask

  task automatic set_issue(logic [4:0] d, logic rw, logic br);
    rif.issue_valid = 1'b1; rif.issue_dest = d; rif.issue_reg_write = rw; rif.issue_is_branch = br;
  endtask

  task automatic set_cdb(logic [3:0] t, logic [31:0] v, logic mp);
    rif.cdb_valid = 1'b1; rif.cdb_ROB = t; rif.cdb_value = v; rif.cdb_mispredict = mp;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rif.issue_valid = 1'b1; rif.Q_j = 4'd0; rif.Q_k = 4'd5;
    settle();
    checks++; if (rif.issue_accept !== 1'b1) begin errors++; $display("FAIL reset_accept: got %0b want 1", rif.issue_accept); end
    checks++; if (rif.issue_ROB !== 4'd0) begin errors++; $display("FAIL reset_issue_rob: got %0d want 0", rif.issue_ROB); end
    checks++; if ({rif.rob_full, rif.rob_empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty: got %b want 01", {rif.rob_full, rif.rob_empty}); end
    checks++; if ({rif.commit_valid, rif.RegWrite, rif.flush} !== 3'b000) begin errors++; $display("FAIL reset_commit: got %b want 000", {rif.commit_valid, rif.RegWrite, rif.flush}); end
    checks++; if ({rif.j_ready, rif.k_ready} !== 2'b00) begin errors++; $display("FAIL reset_lookup: got %b want 00", {rif.j_ready, rif.k_ready}); end
    checks++; if (rif.dbg_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rif.dbg_count); end
    drive_idle();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(5'(5 + i), 1'b1, 1'b0);
      settle();
      checks++; if ({rif.issue_accept, rif.issue_ROB} !== {1'b1, 4'(i)}) begin errors++; $display("FAIL order_issue%0d: got acc=%0b tag=%0d want acc=1 tag=%0d", i, rif.issue_accept, rif.issue_ROB, i); end
      checks++; if (rif.rob_empty !== (i == 0)) begin errors++; $display("FAIL order_empty%0d: got %0b want %0b", i, rif.rob_empty, (i == 0)); end
      checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL order_nocommit%0d: got %0b want 0", i, rif.commit_valid); end
      advance();
    end
    drive_idle();
    set_cdb(4'd1, 32'hAA, 1'b0);
    settle();
    checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL order_tag1_first: got %0b want 0", rif.commit_valid); end
    advance();
    set_cdb(4'd0, 32'h55, 1'b0);
    settle();
    checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL order_tag0_wb: got %0b want 0", rif.commit_valid); end
    advance();
    drive_idle();
    settle();
    checks++; if ({rif.commit_valid, rif.commit_ROB, rif.commit_dest, rif.commit_value, rif.RegWrite} !== {1'b1, 4'd0, 5'd5, 32'h55, 1'b1})
      begin errors++; $display("FAIL order_commit0: got v=%0b tag=%0d d=%0d val=%h rw=%0b want 1/0/5/55/1", rif.commit_valid, rif.commit_ROB, rif.commit_dest, rif.commit_value, rif.RegWrite); end
    advance();
    settle();
    checks++; if ({rif.commit_valid, rif.commit_ROB, rif.commit_dest, rif.commit_value, rif.RegWrite} !== {1'b1, 4'd1, 5'd6, 32'hAA, 1'b1})
      begin errors++; $display("FAIL order_commit1: got v=%0b tag=%0d d=%0d val=%h rw=%0b want 1/1/6/aa/1", rif.commit_valid, rif.commit_ROB, rif.commit_dest, rif.commit_value, rif.RegWrite); end
    advance();
    settle();
    checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL order_tag2_pending: got %0b want 0", rif.commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(5'($urandom_range(1, 31)), 1'b1, 1'b0);
      settle();
      checks++; if (rif.issue_accept !== 1'b1) begin errors++; $display("FAIL fill_accept%0d: got %0b want 1", i, rif.issue_accept); end
      advance();
    end
    settle();
    checks++; if ({rif.rob_full, rif.issue_accept, rif.dbg_count} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("FAIL full_17th: got full=%0b acc=%0b cnt=%0d want 1/0/16", rif.rob_full, rif.issue_accept, rif.dbg_count); end
    advance();
    set_cdb(4'd0, 32'hC0DE, 1'b0);
    settle();
    advance();
    rif.cdb_valid = 1'b0;
    settle();
    checks++; if ({rif.commit_valid, rif.issue_accept} !== 2'b10) begin errors++; $display("FAIL full_commit_noissue: got commit=%0b acc=%0b want 1/0", rif.commit_valid, rif.issue_accept); end
    advance();
    settle();
    checks++; if ({rif.issue_accept, rif.issue_ROB} !== {1'b1, 4'd0}) begin errors++; $display("FAIL wrap_issue: got acc=%0b tag=%0d want 1/0", rif.issue_accept, rif.issue_ROB); end
    advance();
    drive_idle();
    settle();
    checks++; if ({rif.rob_full, rif.dbg_head, rif.dbg_tail} !== {1'b1, 4'd1, 4'd1}) begin errors++; $display("FAIL wrap_state: got full=%0b head=%0d tail=%0d want 1/1/1", rif.rob_full, rif.dbg_head, rif.dbg_tail); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_issue(5'(10 + i), (i != 2), (i == 2));
      settle();
      advance();
    end
    drive_idle();
    set_cdb(4'd0, 32'h10, 1'b0); settle(); advance();
    set_cdb(4'd1, 32'h11, 1'b0); settle(); advance();
    set_cdb(4'd2, 32'h0, 1'b1); settle();
    checks++; if ({rif.commit_valid, rif.commit_ROB, rif.flush} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL flush_pre: got v=%0b tag=%0d fl=%0b want 1/1/0", rif.commit_valid, rif.commit_ROB, rif.flush); end
    advance();
    set_issue(5'd9, 1'b1, 1'b0);
    set_cdb(4'd3, 32'h33, 1'b0);
    settle();
    checks++; if ({rif.flush, rif.commit_valid, rif.commit_ROB, rif.RegWrite, rif.issue_accept} !== {1'b1, 1'b1, 4'd2, 1'b0, 1'b0})
      begin errors++; $display("FAIL flush_cycle: got fl=%0b v=%0b tag=%0d rw=%0b acc=%0b want 1/1/2/0/0", rif.flush, rif.commit_valid, rif.commit_ROB, rif.RegWrite, rif.issue_accept); end
    advance();
    drive_idle();
    rif.Q_j = 4'd3;
    settle();
    checks++; if ({rif.flush, rif.rob_empty, rif.dbg_head, rif.dbg_tail, rif.j_ready, rif.commit_valid} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0})
      begin errors++; $display("FAIL flush_after: got fl=%0b empty=%0b head=%0d tail=%0d jr=%0b v=%0b want 0/1/0/0/0/0", rif.flush, rif.rob_empty, rif.dbg_head, rif.dbg_tail, rif.j_ready, rif.commit_valid); end
    // A mispredicted jump-and-link: RegWrite and flush together.
    set_issue(5'd31, 1'b1, 1'b1);
    settle();
    checks++; if ({rif.issue_accept, rif.issue_ROB} !== {1'b1, 4'd0}) begin errors++; $display("FAIL flush_reissue: got acc=%0b tag=%0d want 1/0", rif.issue_accept, rif.issue_ROB); end
    advance();
    drive_idle();
    set_cdb(4'd0, 32'h400, 1'b1); settle(); advance();
    drive_idle();
    settle();
    checks++; if ({rif.flush, rif.RegWrite, rif.commit_dest, rif.commit_value} !== {1'b1, 1'b1, 5'd31, 32'h400})
      begin errors++; $display("FAIL jal_flush: got fl=%0b rw=%0b d=%0d val=%h want 1/1/31/400", rif.flush, rif.RegWrite, rif.commit_dest, rif.commit_value); end
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    set_issue(5'd0, 1'b1, 1'b0); settle(); advance();
    drive_idle();
    set_cdb(4'd0, 32'h77, 1'b0); settle(); advance();
    drive_idle();
    settle();
    checks++; if ({rif.commit_valid, rif.RegWrite} !== 2'b10) begin errors++; $display("FAIL x0_commit: got v=%0b rw=%0b want 1/0", rif.commit_valid, rif.RegWrite); end
    advance();
  endtask

  task automatic test_lookup();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_issue(5'(1 + i), 1'b1, 1'b0); settle(); advance();
    end
    drive_idle();
    rif.Q_j = 4'd3; rif.Q_k = 4'd2;
    settle();
    checks++; if (rif.j_ready !== 1'b0) begin errors++; $display("FAIL lookup_pending: got %0b want 0", rif.j_ready); end
    set_cdb(4'd3, 32'h1234, 1'b0);
    settle();
`ifdef ROB_BYPASS_EN
    checks++; if ({rif.j_ready, rif.j_value} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL lookup_same_cycle: got r=%0b v=%h want 1/1234", rif.j_ready, rif.j_value); end
`else
    checks++; if (rif.j_ready !== 1'b0) begin errors++; $display("FAIL lookup_same_cycle: got r=%0b want 0", rif.j_ready); end
`endif
    advance();
    rif.cdb_valid = 1'b0;
    settle();
    checks++; if ({rif.j_ready, rif.j_value, rif.k_ready} !== {1'b1, 32'h1234, 1'b0}) begin errors++; $display("FAIL lookup_next_cycle: got jr=%0b jv=%h kr=%0b want 1/1234/0", rif.j_ready, rif.j_value, rif.k_ready); end
  endtask

  task automatic test_random();
    int sz;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sz = mq.size();
      rif.issue_valid = ($urandom_range(0, 99) < 60);
      rif.issue_dest = 5'($urandom_range(0, 31));
      rif.issue_reg_write = ($urandom_range(0, 99) < 80);
      rif.issue_is_branch = ($urandom_range(0, 7) == 0);
      rif.cdb_valid = ($urandom_range(0, 99) < 50);
      rif.cdb_ROB = (sz > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, sz - 1)].tag : 4'($urandom_range(0, 15));
      rif.cdb_value = $urandom;
      rif.cdb_mispredict = ($urandom_range(0, 3) == 0);
      rif.Q_j = (sz > 0 && $urandom_range(0, 2) != 0) ? mq[$urandom_range(0, sz - 1)].tag : 4'($urandom_range(0, 15));
      rif.Q_k = 4'($urandom_range(0, 15));
      settle();
      checks++; if ({rif.issue_accept, rif.rob_full, rif.rob_empty, rif.commit_valid, rif.flush, rif.RegWrite} !== {e_accept, e_full, e_empty, e_commit, e_flush, e_regwrite})
        begin errors++; $display("FAIL rnd_status c%0d: got %b want %b", cyc, {rif.issue_accept, rif.rob_full, rif.rob_empty, rif.commit_valid, rif.flush, rif.RegWrite}, {e_accept, e_full, e_empty, e_commit, e_flush, e_regwrite}); end
      checks++; if ({rif.issue_ROB, rif.dbg_head, rif.dbg_count} !== {m_tail, e_head, e_count})
        begin errors++; $display("FAIL rnd_ptrs c%0d: got tail=%0d head=%0d cnt=%0d want %0d/%0d/%0d", cyc, rif.issue_ROB, rif.dbg_head, rif.dbg_count, m_tail, e_head, e_count); end
      if (e_commit) begin
        checks++; if ({rif.commit_ROB, rif.commit_dest, rif.commit_value} !== {e_head, e_cdest, e_cval})
          begin errors++; $display("FAIL rnd_commit c%0d: got tag=%0d d=%0d v=%h want %0d/%0d/%h", cyc, rif.commit_ROB, rif.commit_dest, rif.commit_value, e_head, e_cdest, e_cval); end
      end
      checks++; if (rif.j_ready !== e_jr || (e_jr && rif.j_value !== e_jv))
        begin errors++; $display("FAIL rnd_j c%0d: got r=%0b v=%h want r=%0b v=%h", cyc, rif.j_ready, rif.j_value, e_jr, e_jv); end
      checks++; if (rif.k_ready !== e_kr || (e_kr && rif.k_value !== e_kv))
        begin errors++; $display("FAIL rnd_k c%0d: got r=%0b v=%h want r=%0b v=%h", cyc, rif.k_ready, rif.k_value, e_kr, e_kv); end
      advance();
    end
    drive_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_tail = 4'd0;
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_in_order();
    test_full_wrap();
    test_flush();
    test_x0();
    test_lookup();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) that allocates ROB tags at issue and captures results from the CDB.
- Retires entries in program order and drives the commit-side interface of the register status table: commit_dest, commit_ROB, RegWrite, and flush into its reset.
- Sits between the issue stage, the CDB and the architectural register file.
- Provides operand-tag lookup so issue can fetch values that are ready but not yet committed.

Parameters:
- TAG_W, 4, ROB tag width; matches the 4-bit ROB_number field in the regstat table.
- DEPTH, 16, number of entries; must equal 2**TAG_W.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- issue_valid  in  1  issue stage requests allocation.
- issue_dest  in  5  destination register of the issuing instruction.
- issue_reg_write  in  1  issuing instruction writes a register.
- issue_is_branch  in  1  issuing instruction is a branch.
- issue_accept  out  1  allocation succeeds this cycle.
- issue_ROB  out  TAG_W  tag allocated (tail pointer); valid when issue_accept=1.
- rob_full  out  1  count==DEPTH.
- rob_empty  out  1  count==0.
- cdb_valid  in  1  result broadcast.
- cdb_ROB  in  TAG_W  tag of the broadcast result.
- cdb_value  in  XLEN  result value.
- cdb_mispredict  in  1  branch result was mispredicted; meaningful only for branch entries.
- Q_j, Q_k  in  TAG_W  operand tags to look up.
- j_ready, k_ready  out  1  looked-up entry is valid and ready.
- j_value, k_value  out  XLEN  looked-up entry's value.
- commit_valid  out  1  head entry retires this cycle.
- commit_ROB  out  TAG_W  head pointer.
- commit_dest  out  5  head destination register.
- commit_value  out  XLEN  head value, for the register file write.
- RegWrite  out  1  commit_valid & head.reg_write & (dest!=0).
- flush  out  1  a mispredicted branch commits; drives regstat reset and front-end flush.

Behaviour:
Entry state:
- Each entry holds valid, ready, reg_write, is_branch, mispredict, dest[4:0] and value[XLEN-1:0].
- Also held: head, tail (TAG_W bits, wrap naturally modulo DEPTH) and count (TAG_W+1 bits).

Reset:
- All valid/ready bits, head, tail and count clear to 0.
- Outputs after reset: issue_accept=issue_valid, issue_ROB=0, rob_full=0, rob_empty=1, commit_valid=0, RegWrite=0, flush=0, j_ready=0, k_ready=0.
- Value fields need not reset; outputs are qualified by valid/ready.

Issue:
- issue_accept = issue_valid & ~rob_full & ~flush. This is combinational.
- On accept: entry[tail] gets valid=1, ready=0, mispredict=0, plus dest, reg_write and is_branch. tail increments.
- Fullness is conservative: a commit in the same cycle does not free a slot for a same-cycle issue.

Writeback:
- When cdb_valid and entry[cdb_ROB].valid, set ready=1 and store value. Branches also store mispredict.
- A CDB write to an invalid entry is ignored.

Commit:
- commit_valid = entry[head].valid & entry[head].ready. This is combinational from registered state, so regstat sees commit and issue in the same cycle.
- On commit: clear entry[head].valid and increment head.
- One commit per cycle.
- flush = commit_valid & head.is_branch & head.mispredict.
- On flush:
  - Next state clears every valid bit and sets head=tail=count=0.
  - Any same-cycle issue is not accepted.
  - Any same-cycle CDB write is discarded.
- The mispredicted branch itself does not assert RegWrite unless reg_write is set (e.g. JAL link register). In that case RegWrite and flush assert together.

Count update:
- count updates by +accept −commit; a simultaneous issue and commit leaves it unchanged.

Operand lookup:
- j_ready = entry[Q_j].valid & entry[Q_j].ready, and j_value = entry[Q_j].value. k_ready/k_value are the same for Q_k.
- Lookup is combinational.

Boundary conditions:
- Wrap: tail 15→0 and head 15→0 wrap with no gap.
- Empty: commit_valid=0.
- Full: issue_accept=0, no state change from issue.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: when cdb_valid & cdb_ROB==Q_j and entry[Q_j].valid, j_ready=1 and j_value=cdb_value in the same cycle. Q_k behaves the same way.
- Not defined: lookup reflects registered entry state only, so a result is visible one cycle after its CDB broadcast.

Test Plan:
- Reset then issue 3 instructions (dest x5,x6,x7, reg_write=1) → issue_ROB 0,1,2; rob_empty falls after the first edge; commit_valid stays 0.
- CDB writes tag 1 value 0xAA, then tag 0 value 0x55 → tag 0 commits first (commit_dest=5, commit_value=0x55, RegWrite=1), then tag 1 (dest 6, 0xAA) on the next cycle; strictly in order.
- Issue 16 with none completed → rob_full=1; 17th request gets issue_accept=0. Then complete and commit tag 0 while issue_valid=1 → that cycle still no accept; next cycle accepted with issue_ROB=0 (wrap).
- Branch at tag 2 with younger tags 3,4 issued; CDB tag 2 mispredict=1 after tags 0,1 commit → flush=1 for one cycle; next cycle rob_empty=1, head=tail=0, next issue gets issue_ROB=0.
- Instruction with dest x0, reg_write=1 commits → commit_valid=1, RegWrite=0.
- Lookup Q_j=3 when tag 3 is pending: j_ready=0. CDB on tag 3 with value 0x1234 → with ROB_BYPASS_EN, j_ready=1 and j_value=0x1234 in the same cycle; without it, both appear the following cycle.
